// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use interlock, taken-branch flush and
// memory-wait freeze, plus a saturating stall counter and a sticky wait timeout.
module hazard_stall_controller #(
  parameter int unsigned REG_SIZE   = 5,
  parameter logic [15:0] WAIT_LIMIT = 16'd255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REG_SIZE-1:0] ID_Rs1_i,
  input  logic [REG_SIZE-1:0] ID_Rs2_i,
  input  logic                EX_MemRead_i,
  input  logic [REG_SIZE-1:0] EX_Rd_i,
  input  logic                Branch_taken_i,
  input  logic                Mem_req_i,
  input  logic                Mem_ack_i,
  output logic                PC_write_o,
  output logic                IFID_write_o,
  output logic                IDEX_bubble_o,
  output logic                IFID_flush_o,
  output logic                Freeze_o,
  output logic [15:0]         Stall_cnt_o,
  output logic                Timeout_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_timeout;

  logic w_mem_busy;
  logic w_load_use;

  // Hazard detection and prioritised pipeline control, zero-cycle latency
  always_comb begin
    w_mem_busy    = 1'b0;
    w_load_use    = 1'b0;
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IDEX_bubble_o = 1'b0;
    IFID_flush_o  = 1'b0;
    Freeze_o      = 1'b0;

    w_mem_busy = ((r_state == IDLE) && Mem_req_i && !Mem_ack_i) ||
                 ((r_state == MEM_WAIT) && !Mem_ack_i);
    w_load_use = EX_MemRead_i && (EX_Rd_i != REG_SIZE'(0)) &&
                 ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

    if (rst_i) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
      IFID_flush_o  = 1'b1;
      Freeze_o      = 1'b0;
    end else if (w_mem_busy) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      Freeze_o      = 1'b1;
    end else if (w_load_use) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o  = 1'b1;
    end
  end

  // Memory-wait FSM, stall statistics and sticky timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 16'd0;
      r_stall_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Mem_req_i && !Mem_ack_i) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (Mem_ack_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= 16'd0;
          end else begin
            if (r_wait_cnt == WAIT_LIMIT) r_timeout <= 1'b1;
            if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= 16'd0;
        end
      endcase

      if ((w_mem_busy || w_load_use) && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign Stall_cnt_o = r_stall_cnt;
  assign Timeout_o   = r_timeout;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios followed by
// constrained-random traffic, all compared against a behavioural model.
module tb_hazard_stall_controller;

  localparam int unsigned RS = 5;
  localparam int          LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RS-1:0] rs1, rs2, rd;
  logic          memread, br, req, ack;
  logic          pc_w, ifid_w, bubble, flush, freeze, timeout;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state, kept as plain integers
  bit m_waiting = 0;
  int m_wait    = 0;
  int m_stall   = 0;
  bit m_timeout = 0;

  hazard_stall_controller #(.REG_SIZE(RS), .WAIT_LIMIT(16'(LIMIT))) dut (
    .clk_i(clk), .rst_i(rst), .ID_Rs1_i(rs1), .ID_Rs2_i(rs2),
    .EX_MemRead_i(memread), .EX_Rd_i(rd), .Branch_taken_i(br),
    .Mem_req_i(req), .Mem_ack_i(ack), .PC_write_o(pc_w), .IFID_write_o(ifid_w),
    .IDEX_bubble_o(bubble), .IFID_flush_o(flush), .Freeze_o(freeze),
    .Stall_cnt_o(stall_cnt), .Timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, check everything mid-cycle, then advance the model
  task automatic step(input bit r, input int a1, input int a2, input bit mr,
                      input int d, input bit b, input bit q, input bit k);
    bit busy, lu;
    bit e_pc, e_ifid, e_bub, e_fl, e_fz;
    rst = r; rs1 = RS'(a1); rs2 = RS'(a2); memread = mr; rd = RS'(d);
    br = b; req = q; ack = k;
    busy = m_waiting ? !k : (q && !k);
    lu   = mr && (d != 0) && (d == a1 || d == a2);
    if (r) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 1; e_fz = 0;
    end else if (busy) begin
      e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0; e_fz = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 0; e_fz = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = b; e_fz = 0;
    end
    @(negedge clk);
    chk("pc_write",    16'(pc_w),    16'(e_pc));
    chk("ifid_write",  16'(ifid_w),  16'(e_ifid));
    chk("idex_bubble", 16'(bubble),  16'(e_bub));
    chk("ifid_flush",  16'(flush),   16'(e_fl));
    chk("freeze",      16'(freeze),  16'(e_fz));
    chk("stall_cnt",   stall_cnt,    16'(m_stall));
    chk("timeout",     16'(timeout), 16'(m_timeout));
    @(posedge clk);
    if (r) begin
      m_waiting = 0; m_wait = 0; m_stall = 0; m_timeout = 0;
    end else begin
      if (busy || lu) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (m_waiting) begin
        if (k) begin
          m_waiting = 0; m_wait = 0;
        end else begin
          if (m_wait == LIMIT) m_timeout = 1;
          m_wait = (m_wait < 65535) ? m_wait + 1 : 65535;
        end
      end else if (q && !k) begin
        m_waiting = 1; m_wait = 1;
      end
    end
    #1;
  endtask

  task automatic idle_step();
    step(0, 1, 2, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_step();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pend;
    bit q, k, r;
    rst = 1; rs1 = '0; rs2 = '0; rd = '0; memread = 0; br = 0; req = 0; ack = 0;
    #1;

    // Reset forces outputs and clears counters; reset held with random junk
    step(1, 3, 3, 1, 3, 1, 1, 0);
    reset_step();
    idle_step();
    chk("reset_stall_zero", stall_cnt, 16'd0);

    // Load-use on Rs2: one bubble cycle, count becomes 1
    step(0, 7, 5, 1, 5, 0, 0, 0);
    idle_step();
    chk("lu_rs2_stall_one", stall_cnt, 16'd1);

    // x0 destination never interlocks
    reset_step();
    step(0, 0, 9, 1, 0, 0, 0, 0);
    idle_step();
    chk("x0_no_stall", stall_cnt, 16'd0);

    // Three wait cycles, then ack with freeze low
    reset_step();
    step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 1);
    chk("memwait_stall_three", stall_cnt, 16'd3);
    idle_step();
    step(0, 1, 2, 0, 0, 0, 0, 1);
    step(0, 1, 2, 0, 0, 0, 1, 1);
    chk("single_cycle_access", stall_cnt, 16'd3);

    // Branch together with load-use: bubble first, flush next cycle
    reset_step();
    step(0, 6, 0, 1, 6, 1, 0, 0);
    step(0, 6, 0, 0, 6, 1, 0, 0);
    chk("branch_after_lu_stall", stall_cnt, 16'd1);

    // Memory busy outranks both load-use and branch
    step(0, 4, 4, 1, 4, 1, 1, 0);
    step(0, 4, 4, 1, 4, 1, 1, 1);

    // Timeout after the LIMIT-th wait cycle, sticky through ack, cleared by reset
    reset_step();
    for (int i = 0; i < LIMIT + 3; i++) step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 1);
    idle_step();
    chk("timeout_sticky", 16'(timeout), 16'd1);
    step(1, 1, 2, 0, 0, 0, 1, 0);
    idle_step();
    chk("timeout_cleared", 16'(timeout), 16'd0);

    // Reset during a wait abandons the access
    step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 0);
    reset_step();
    step(0, 1, 2, 0, 0, 0, 0, 1);
    idle_step();

    // Random traffic; requests stay up until acknowledged
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) < 2);
      q = pend ? 1'b1 : ($urandom_range(0, 3) == 0);
      k = ($urandom_range(0, 2) == 0);
      step(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3), $urandom_range(0, 2) == 0, q, k);
      pend = !r && q && !k;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 The block SHALL have parameter REG_SIZE, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter WAIT_LIMIT, default 16'd255, meaning the MEM_WAIT cycle count that raises timeout_o.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port ID_Rs1_i, input, REG_SIZE, source register 1 of the instruction in ID.
REQ-006 The block SHALL have port ID_Rs2_i, input, REG_SIZE, source register 2 of the instruction in ID.
REQ-007 The block SHALL have port EX_MemRead_i, input, 1, EX instruction is a load.
REQ-008 The block SHALL have port EX_Rd_i, input, REG_SIZE, destination register of the EX instruction.
REQ-009 The block SHALL have port Branch_taken_i, input, 1, branch resolved taken in ID.
REQ-010 The block SHALL have port Mem_req_i, input, 1, MEM stage holds a valid load/store; held high until acknowledged.
REQ-011 The block SHALL have port Mem_ack_i, input, 1, data memory completes the access this cycle.
REQ-012 The block SHALL have port PC_write_o, output, 1, PC update enable.
REQ-013 The block SHALL have port IFID_write_o, output, 1, IF/ID register update enable.
REQ-014 The block SHALL have port IDEX_bubble_o, output, 1, load NOP controls into ID/EX.
REQ-015 The block SHALL have port IFID_flush_o, output, 1, clear IF/ID to NOP.
REQ-016 The block SHALL have port Freeze_o, output, 1, hold every pipeline register (PC through MEM/WB).
REQ-017 The block SHALL have port Stall_cnt_o, output, 16, saturating count of stall cycles.
REQ-018 The block SHALL have port Timeout_o, output, 1, sticky memory-wait timeout flag.

Function
REQ-019 The FSM SHALL have two states, IDLE and MEM_WAIT, with a 16-bit wait counter.
REQ-020 IDLE -> MEM_WAIT SHALL occur when Mem_req_i=1 and Mem_ack_i=0; wait counter loads 1.
REQ-021 MEM_WAIT -> IDLE SHALL occur on Mem_ack_i=1; otherwise the wait counter SHALL increment, saturating at 16'hFFFF.
REQ-022 Mem_req_i=1 with Mem_ack_i=1 in IDLE SHALL stay in IDLE with zero freeze (single-cycle access).
REQ-023 mem_busy SHALL be (IDLE and Mem_req_i and !Mem_ack_i) or (MEM_WAIT and !Mem_ack_i), combinational; Freeze_o = mem_busy.
REQ-024 load_use SHALL be EX_MemRead_i and EX_Rd_i!=0 and (EX_Rd_i==ID_Rs1_i or EX_Rd_i==ID_Rs2_i).
REQ-025 Priority 1: mem_busy -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=0, IFID_flush_o=0; Branch_taken_i and load_use ignored.
REQ-026 Priority 2: load_use -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=0; Branch_taken_i ignored this cycle (re-evaluated next cycle).
REQ-027 Priority 3: Branch_taken_i -> PC_write_o=1, IFID_write_o=1, IDEX_bubble_o=0, IFID_flush_o=1.
REQ-028 Otherwise, PC_write_o=1, IFID_write_o=1, IDEX_bubble_o=0, IFID_flush_o=0.
REQ-029 All control outputs SHALL be combinational with zero-cycle latency from inputs and current state.
REQ-030 Stall_cnt_o SHALL increment by 1 on each clock edge where mem_busy or load_use was 1, saturating at 16'hFFFF with no wrap.
REQ-031 Timeout_o SHALL set on the edge where state is MEM_WAIT, Mem_ack_i=0, and wait counter == WAIT_LIMIT, and SHALL remain set until reset; FSM behaviour is unaffected.
REQ-032 Mem_ack_i while Mem_req_i=0 in IDLE SHALL be ignored.

Reset
REQ-033 On a rising edge with rst_i=1, state SHALL go to IDLE, wait counter, Stall_cnt_o, and Timeout_o SHALL go to 0.
REQ-034 While rst_i=1, outputs SHALL be forced: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=1, Freeze_o=0, regardless of other inputs.
REQ-035 Reset asserted during MEM_WAIT SHALL abandon the access; the first cycle after reset is IDLE.

Verification
REQ-036 EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5 -> one cycle PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; Stall_cnt_o=1 next cycle.
REQ-037 EX_MemRead_i=1, EX_Rd_i=0, ID_Rs1_i=0 -> no stall, PC_write_o=1, IDEX_bubble_o=0.
REQ-038 Mem_req_i=1, Mem_ack_i low 3 cycles, then high -> Freeze_o=1 for 3 cycles, 0 in the ack cycle; Stall_cnt_o=3; state IDLE after ack.
REQ-039 Branch_taken_i=1 together with load_use -> bubble only, IFID_flush_o=0; next cycle, load_use clear -> IFID_flush_o=1, PC_write_o=1.
REQ-040 WAIT_LIMIT=4, Mem_ack_i held 0 -> Timeout_o rises after the 4th MEM_WAIT cycle edge and stays 1 after ack; rst_i pulse clears it to 0.
